// File: rtl/rvm_ddr3_pkg.sv
// Shared definitions for the rvm_core to DDR3 (MIG) bridge.
package rvm_ddr3_pkg;

  localparam logic [2:0] CMD_WR     = 3'b000;
  localparam logic [2:0] CMD_RD     = 3'b001;
  localparam int         LINE_BYTES = 16;
  localparam int         TAG_BITS   = 24;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    WR_XFER,
    RESP
  } state_t;

  // Pick 32-bit lane 'sel' out of a 128-bit line.
  function automatic logic [31:0] select_word(input logic [127:0] line, input logic [1:0] sel);
    return line[32*sel +: 32];
  endfunction

endpackage

// File: rtl/rvm_ddr3_linebuf.sv
// One-line read buffer: holds the last DDR3 line read, answers tag hits with
// a selected word, and takes write-through byte merges for the same line.
module rvm_ddr3_linebuf
  import rvm_ddr3_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                fill,
  input  logic [127:0]        fill_line,
  input  logic                invalidate,
  input  logic                merge,
  input  logic [127:0]        merge_data,
  input  logic [15:0]         merge_be,
  input  logic [TAG_BITS-1:0] lookup_tag,
  input  logic [1:0]          word_sel,
  output logic                hit,
  output logic [31:0]         word
);

  logic [127:0]        line;
  logic [TAG_BITS-1:0] tag;
  logic                valid;

  assign hit  = valid && (tag == lookup_tag);
  assign word = select_word(line, word_sel);

  // Line storage: invalidation wins over a fill, a fill wins over a merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line  <= '0;
      tag   <= '0;
      valid <= 1'b0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (fill) begin
      line  <= fill_line;
      tag   <= lookup_tag;
      valid <= 1'b1;
    end else if (merge && hit) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (merge_be[i]) line[8*i +: 8] <= merge_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/rvm_ddr3_bridge.sv
// Bridges the rvm_core 32-bit memory port onto the MIG 128-bit application
// interface, one 16-byte line command per core request, in the ui_clk domain.
module rvm_ddr3_bridge
  import rvm_ddr3_pkg::*;
#(
  parameter int LINE_BUF_EN    = 1,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ADDR_BITS      = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  mem_addr,
  output logic [31:0]  mem_rdata,
  input  logic [31:0]  mem_wdata,
  input  logic         mem_c_en,
  input  logic         mem_w_en,
  input  logic [3:0]   mem_b_en,
  output logic         mem_error,
  output logic         mem_stall,
  input  logic         init_calib_complete,
  output logic [27:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  output logic [127:0] app_wdf_data,
  output logic [15:0]  app_wdf_mask,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_end,
  input  logic         app_rd_data_valid,
  input  logic         app_rdy,
  input  logic         app_wdf_rdy
);

  localparam int TIMER_BITS = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state, state_next;
  logic                  resp;
  logic                  cmd_acc, cmd_acc_next;
  logic                  wdf_acc, wdf_acc_next;
  logic [TIMER_BITS-1:0] timer;
  logic                  timed_out;

  logic                  app_en_next, app_wdf_wren_next, mem_error_next;
  logic [2:0]            app_cmd_next;
  logic [27:0]           app_addr_next;
  logic [31:0]           mem_rdata_next;

  logic                  out_of_range;
  logic [15:0]           byte_en;
  logic                  buf_hit, line_hit, buf_fill, buf_inval, buf_merge;
  logic [31:0]           buf_word;
  logic                  unused_ok;

  assign out_of_range = |(mem_addr >> ADDR_BITS);
  assign byte_en      = 16'(mem_b_en) << {mem_addr[3:2], 2'b00};
  assign app_wdf_mask = ~byte_en;
  assign app_wdf_data = {4{mem_wdata}};
  assign app_wdf_end  = app_wdf_wren;
  assign mem_stall    = mem_c_en & ~resp;
  assign timed_out    = (timer == TIMER_BITS'(TIMEOUT_CYCLES));
  assign line_hit     = (LINE_BUF_EN != 0) && buf_hit;
  assign unused_ok    = ^{app_rd_data_end, mem_addr[1:0]};

  rvm_ddr3_linebuf u_linebuf (
    .clk        (clk),
    .reset      (reset),
    .fill       (buf_fill),
    .fill_line  (app_rd_data),
    .invalidate (buf_inval),
    .merge      (buf_merge),
    .merge_data (app_wdf_data),
    .merge_be   (byte_en),
    .lookup_tag (mem_addr[27:4]),
    .word_sel   (mem_addr[3:2]),
    .hit        (buf_hit),
    .word       (buf_word)
  );

  // Next-state and next-output decode for the request sequencer.
  always_comb begin
    state_next        = state;
    app_en_next       = app_en;
    app_wdf_wren_next = app_wdf_wren;
    app_cmd_next      = app_cmd;
    app_addr_next     = app_addr;
    mem_rdata_next    = mem_rdata;
    mem_error_next    = mem_error;
    cmd_acc_next      = cmd_acc;
    wdf_acc_next      = wdf_acc;
    buf_fill          = 1'b0;
    buf_inval         = 1'b0;
    buf_merge         = 1'b0;

    case (state)
      IDLE: begin
        if (mem_c_en && init_calib_complete) begin
          if (out_of_range) begin
            state_next     = RESP;
            mem_error_next = 1'b1;
          end else if (!mem_w_en && line_hit) begin
            state_next     = RESP;
            mem_rdata_next = buf_word;
          end else if (!mem_w_en) begin
            state_next    = RD_CMD;
            app_en_next   = 1'b1;
            app_cmd_next  = CMD_RD;
            app_addr_next = {1'b0, mem_addr[27:4], 3'b000};
          end else begin
            state_next        = WR_XFER;
            app_en_next       = 1'b1;
            app_wdf_wren_next = 1'b1;
            app_cmd_next      = CMD_WR;
            app_addr_next     = {1'b0, mem_addr[27:4], 3'b000};
            cmd_acc_next      = 1'b0;
            wdf_acc_next      = 1'b0;
            buf_merge         = (LINE_BUF_EN != 0);
          end
        end
      end

      RD_CMD: begin
        if (app_rdy) begin
          app_en_next = 1'b0;
          state_next  = RD_WAIT;
        end else if (timed_out) begin
          app_en_next    = 1'b0;
          state_next     = RESP;
          mem_error_next = 1'b1;
          buf_inval      = 1'b1;
        end
      end

      RD_WAIT: begin
        if (app_rd_data_valid) begin
          buf_fill       = (LINE_BUF_EN != 0);
          mem_rdata_next = select_word(app_rd_data, mem_addr[3:2]);
          state_next     = RESP;
        end else if (timed_out) begin
          state_next     = RESP;
          mem_error_next = 1'b1;
          buf_inval      = 1'b1;
        end
      end

      WR_XFER: begin
        cmd_acc_next      = cmd_acc | (app_en & app_rdy);
        wdf_acc_next      = wdf_acc | (app_wdf_wren & app_wdf_rdy);
        app_en_next       = app_en & ~app_rdy;
        app_wdf_wren_next = app_wdf_wren & ~app_wdf_rdy;
        if (cmd_acc_next && wdf_acc_next) begin
          state_next = RESP;
        end else if (timed_out) begin
          app_en_next       = 1'b0;
          app_wdf_wren_next = 1'b0;
          state_next        = RESP;
          mem_error_next    = 1'b1;
          buf_inval         = 1'b1;
        end
      end

      RESP: begin
        state_next     = IDLE;
        mem_error_next = 1'b0;
      end

      default: state_next = IDLE;
    endcase
  end

  // State, registered outputs and the per-state timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_cmd      <= CMD_RD;
      app_addr     <= '0;
      mem_rdata    <= '0;
      mem_error    <= 1'b0;
      resp         <= 1'b0;
      cmd_acc      <= 1'b0;
      wdf_acc      <= 1'b0;
      timer        <= '0;
    end else begin
      state        <= state_next;
      app_en       <= app_en_next;
      app_wdf_wren <= app_wdf_wren_next;
      app_cmd      <= app_cmd_next;
      app_addr     <= app_addr_next;
      mem_rdata    <= mem_rdata_next;
      mem_error    <= mem_error_next;
      resp         <= (state_next == RESP);
      cmd_acc      <= cmd_acc_next;
      wdf_acc      <= wdf_acc_next;
      if (state_next != state) timer <= '0;
      else if (!timed_out)     timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_rvm_ddr3_bridge.sv
// Self-checking bench for rvm_ddr3_bridge: a small MIG model answers the
// bridge, and a scoreboard queue holds the expected response of each request.
module tb_rvm_ddr3_bridge;
  import rvm_ddr3_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  mem_addr = '0;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_wdata = '0;
  logic         mem_c_en = 1'b0;
  logic         mem_w_en = 1'b0;
  logic [3:0]   mem_b_en = '0;
  logic         mem_error;
  logic         mem_stall;
  logic         init_calib_complete = 1'b0;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [127:0] app_rd_data = '0;
  logic         app_rd_data_end = 1'b0;
  logic         app_rd_data_valid = 1'b0;
  logic         app_rdy = 1'b1;
  logic         app_wdf_rdy = 1'b1;

  rvm_ddr3_bridge dut (
    .clk                 (clk),
    .reset               (reset),
    .mem_addr            (mem_addr),
    .mem_rdata           (mem_rdata),
    .mem_wdata           (mem_wdata),
    .mem_c_en            (mem_c_en),
    .mem_w_en            (mem_w_en),
    .mem_b_en            (mem_b_en),
    .mem_error           (mem_error),
    .mem_stall           (mem_stall),
    .init_calib_complete (init_calib_complete),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_rd_data         (app_rd_data),
    .app_rd_data_end     (app_rd_data_end),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
  } sb_item_t;

  sb_item_t     exp_q[$];
  logic [127:0] ref_mem [logic [23:0]];
  logic [127:0] ddr_mem [logic [23:0]];

  int n_compared = 0;
  int n_mismatched = 0;

  // Control from the main sequence, read by the MIG model.
  logic suppress_rd = 1'b0;
  int   stray_req = 0;

  // Statistics and state owned by the MIG model.
  int          stray_done = 0;
  int          app_en_cycles = 0;
  int          rd_cmds = 0;
  int          completions = 0;
  logic        rd_pending = 1'b0;
  int          rd_delay = 0;
  logic [23:0] rd_line = '0;

  // Power-on contents of the DDR3 array, shared by the model and the reference.
  function automatic logic [127:0] initLine(input logic [23:0] line);
    if (line == 24'h000010)
      return {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    return {4{8'h00, line}};
  endfunction

  function automatic logic [127:0] getRef(input logic [23:0] line);
    if (ref_mem.exists(line)) return ref_mem[line];
    return initLine(line);
  endfunction

  function automatic logic [127:0] getDdr(input logic [23:0] line);
    if (ddr_mem.exists(line)) return ddr_mem[line];
    return initLine(line);
  endfunction

  // MIG model: samples 2 ns after each rising edge, accepts commands and
  // write data, returns read lines after a short latency, injects stray beats.
  always @(posedge clk) begin
    logic [127:0] l;
    #2;
    if (reset) begin
      rd_pending = 1'b0;
      app_rd_data_valid = 1'b0;
    end else begin
      app_rd_data_valid = 1'b0;
      if (rd_pending) begin
        if (rd_delay == 0) begin
          app_rd_data = getDdr(rd_line);
          app_rd_data_valid = 1'b1;
          rd_pending = 1'b0;
        end else begin
          rd_delay--;
        end
      end else if (stray_done != stray_req) begin
        app_rd_data = {4{32'hDEADBEEF}};
        app_rd_data_valid = 1'b1;
        stray_done++;
      end
      if (app_en) app_en_cycles++;
      if (app_en && app_rdy && app_cmd == CMD_RD) begin
        rd_cmds++;
        if (!suppress_rd) begin
          rd_pending = 1'b1;
          rd_delay = 2;
          rd_line = app_addr[26:3];
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        l = getDdr(app_addr[26:3]);
        for (int b = 0; b < 16; b++)
          if (!app_wdf_mask[b]) l[8*b +: 8] = app_wdf_data[8*b +: 8];
        ddr_mem[app_addr[26:3]] = l;
      end
      if (mem_c_en && !mem_stall) completions++;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one core request at a falling edge and queue its expected response.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                               input logic [3:0] be, input logic exp_err);
    sb_item_t     item;
    logic [127:0] l;
    logic [1:0]   lane;
    @(negedge clk);
    mem_addr  = addr;
    mem_w_en  = we;
    mem_wdata = wdata;
    mem_b_en  = be;
    mem_c_en  = 1'b1;
    lane = addr[3:2];
    l = getRef(addr[27:4]);
    item.err      = exp_err || (addr[31:28] != 4'h0);
    item.chk_data = !we && !item.err;
    item.rdata    = l[32*lane +: 32];
    if (we && !item.err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) l[32*lane + 8*i +: 8] = wdata[8*i +: 8];
      ref_mem[addr[27:4]] = l;
    end
    exp_q.push_back(item);
    #1;
  endtask

  // Wait (bounded) for completion, then pop and compare the scoreboard entry.
  task automatic waitCompletion(input string tag, input int budget, output int stalls);
    sb_item_t item;
    bit       done = 1'b0;
    stalls = 0;
    for (int c = 0; c < budget && !done; c++) begin
      if (!mem_stall) done = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
        #1;
      end
    end
    item = exp_q.pop_front();
    if (!done) begin
      checkOutput({tag, "_completion"}, 128'(mem_stall), 128'(0));
    end else begin
      checkOutput({tag, "_error"}, 128'(mem_error), 128'(item.err));
      if (item.chk_data) checkOutput({tag, "_rdata"}, 128'(mem_rdata), 128'(item.rdata));
    end
    mem_c_en = 1'b0;
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_app_en"}, 128'(app_en), 128'(0));
    checkOutput({pfx, "_wdf_wren"}, 128'(app_wdf_wren), 128'(0));
    checkOutput({pfx, "_wdf_end"}, 128'(app_wdf_end), 128'(0));
    checkOutput({pfx, "_app_cmd"}, 128'(app_cmd), 128'(3'b001));
    checkOutput({pfx, "_app_addr"}, 128'(app_addr), 128'(0));
    checkOutput({pfx, "_rdata"}, 128'(mem_rdata), 128'(0));
    checkOutput({pfx, "_error"}, 128'(mem_error), 128'(0));
  endtask

  initial begin
    int stalls, rd0, en0, cp0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("rst");
    checkOutput("rst_stall", 128'(mem_stall), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // Calibration gating: the request must wait for init_calib_complete.
    en0 = app_en_cycles;
    applyStimulus(32'h0000_0100, 1'b0, '0, 4'h0, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("calib_stall", 128'(mem_stall), 128'(1));
    checkOutput("calib_no_app_en", 128'(app_en_cycles - en0), 128'(0));
    init_calib_complete = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("calib_app_en", 128'(app_en), 128'(1));
    checkOutput("calib_app_addr", 128'(app_addr), 128'(28'h80));
    checkOutput("calib_app_cmd", 128'(app_cmd), 128'(3'b001));
    waitCompletion("calib_rd", 50, stalls);

    // Reset pulse empties the line buffer.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Read miss then hit on the same line.
    rd0 = rd_cmds;
    applyStimulus(32'h0000_0104, 1'b0, '0, 4'h0, 1'b0);
    waitCompletion("miss_rd", 50, stalls);
    checkOutput("miss_rd_cmds", 128'(rd_cmds - rd0), 128'(1));
    rd0 = rd_cmds;
    en0 = app_en_cycles;
    applyStimulus(32'h0000_010C, 1'b0, '0, 4'h0, 1'b0);
    waitCompletion("hit_rd", 50, stalls);
    checkOutput("hit_stalls", 128'(stalls), 128'(1));
    checkOutput("hit_no_app_en", 128'(app_en_cycles - en0), 128'(0));

    // Write-through merge into the buffered line, then a hit read-back.
    applyStimulus(32'h0000_0104, 1'b1, 32'hFFFFFFFF, 4'b1000, 1'b0);
    waitCompletion("merge_wr", 50, stalls);
    rd0 = rd_cmds;
    applyStimulus(32'h0000_0104, 1'b0, '0, 4'h0, 1'b0);
    waitCompletion("merge_rd", 50, stalls);
    checkOutput("merge_rd_cmds", 128'(rd_cmds - rd0), 128'(0));
    checkOutput("merge_word", 128'(mem_rdata), 128'(32'hFFBBBBBB));

    // Byte write with app_rdy held off three cycles past app_wdf_rdy.
    app_rdy = 1'b0;
    cp0 = completions;
    applyStimulus(32'h0000_0208, 1'b1, 32'h11223344, 4'b0101, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("bw_mask", 128'(app_wdf_mask), 128'(16'hFAFF));
    checkOutput("bw_wdata", app_wdf_data, {4{32'h11223344}});
    checkOutput("bw_cmd", 128'(app_cmd), 128'(3'b000));
    checkOutput("bw_app_en_held", 128'(app_en), 128'(1));
    checkOutput("bw_wren_dropped", 128'(app_wdf_wren), 128'(0));
    checkOutput("bw_still_stalled", 128'(mem_stall), 128'(1));
    app_rdy = 1'b1;
    waitCompletion("bw_wr", 50, stalls);
    repeat (2) @(negedge clk);
    checkOutput("bw_one_resp", 128'(completions - cp0), 128'(1));
    applyStimulus(32'h0000_0208, 1'b0, '0, 4'h0, 1'b0);
    waitCompletion("bw_rd", 50, stalls);

    // Out-of-range address: error with no DDR3 traffic.
    en0 = app_en_cycles;
    applyStimulus(32'h1000_0000, 1'b0, '0, 4'h0, 1'b1);
    waitCompletion("oor_rd", 50, stalls);
    checkOutput("oor_no_app_en", 128'(app_en_cycles - en0), 128'(0));

    // Write with no byte enables is still issued, fully masked.
    applyStimulus(32'h0000_0300, 1'b1, 32'h55AA55AA, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("nobe_mask", 128'(app_wdf_mask), 128'(16'hFFFF));
    waitCompletion("nobe_wr", 50, stalls);

    // Read data withheld: timeout error, then a stray beat is ignored.
    suppress_rd = 1'b1;
    applyStimulus(32'h0000_0304, 1'b0, '0, 4'h0, 1'b1);
    waitCompletion("tmo_rd", 3000, stalls);
    @(negedge clk);
    #1;
    checkOutput("tmo_err_cleared", 128'(mem_error), 128'(0));
    suppress_rd = 1'b0;
    stray_req++;
    repeat (4) @(negedge clk);
    rd0 = rd_cmds;
    applyStimulus(32'h0000_0208, 1'b0, '0, 4'h0, 1'b0);
    waitCompletion("post_tmo_rd", 50, stalls);
    checkOutput("post_tmo_miss", 128'(rd_cmds - rd0), 128'(1));

    // Reset while waiting for read data aborts and clears the buffer.
    applyStimulus(32'h0000_0104, 1'b0, '0, 4'h0, 1'b0);
    waitCompletion("pre_rst_rd", 50, stalls);
    suppress_rd = 1'b1;
    applyStimulus(32'h0000_0300, 1'b0, '0, 4'h0, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetOutputs("midrst");
    checkOutput("midrst_stall", 128'(mem_stall), 128'(1));
    @(negedge clk);
    mem_c_en = 1'b0;
    void'(exp_q.pop_back());
    reset = 1'b0;
    suppress_rd = 1'b0;
    rd0 = rd_cmds;
    applyStimulus(32'h0000_0104, 1'b0, '0, 4'h0, 1'b0);
    waitCompletion("post_rst_rd", 50, stalls);
    checkOutput("post_rst_miss", 128'(rd_cmds - rd0), 128'(1));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
